// File: rtl/evm_key_pkg.sv
// Shared widths, defaults and FSM state type for the final-key schedule.
package evm_key_pkg;

   localparam int unsigned KEY_W = 64;
   localparam int unsigned SID_W = 16;
   localparam int unsigned CTR_W = 8;

   localparam int unsigned DEF_ROUNDS = 16;
   localparam int unsigned DEF_ROT    = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/final_key_generator_key_round.sv
// One key-schedule round: rotl(k,ROT) ^ (k>>3) ^ {4{sid}} ^ zero_ext(i).
module key_round
   import evm_key_pkg::*;
#(
   parameter int unsigned ROT = DEF_ROT
) (
   input  logic [0:KEY_W-1] k,
   input  logic [0:SID_W-1] sid,
   input  logic [0:CTR_W-1] i,
   output logic [0:KEY_W-1] k_next
);

   logic [KEY_W-1:0] kv;
   logic [KEY_W-1:0] rotated;
   logic [KEY_W-1:0] shifted;
   logic [KEY_W-1:0] mix;

   // Index 0 of the ascending ports is the MSB, so a plain copy keeps integer value.
   always_comb begin
      kv      = k;
      rotated = (kv << ROT) | (kv >> (KEY_W - ROT));
      shifted = kv >> 3;
      mix     = {4{sid}} ^ {{(KEY_W - CTR_W){1'b0}}, i};
      k_next  = rotated ^ shifted ^ mix;
   end

endmodule

// File: rtl/final_key_generator.sv
// Iterative key schedule: expands seed_key/session_id over ROUNDS clocked rounds.
module final_key_generator
   import evm_key_pkg::*;
#(
   parameter int unsigned ROUNDS = DEF_ROUNDS,
   parameter int unsigned ROT    = DEF_ROT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [0:63]     seed_key,
   input  logic [0:15]     session_id,
   output logic            busy,
   output logic            done,
   output logic            key_valid,
   output logic [0:63]     final_key
);

   localparam logic [CTR_W-1:0] LAST = CTR_W'(ROUNDS - 1);

   state_t           state;
   state_t           state_next;
   logic [KEY_W-1:0] k;
   logic [KEY_W-1:0] k_round;
   logic [SID_W-1:0] sid;
   logic [CTR_W-1:0] ctr;

   key_round #(
      .ROT(ROT)
   ) u_round (
      .k      (k),
      .sid    (sid),
      .i      (ctr),
      .k_next (k_round)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (start && !abort) state_next = RUN;
         RUN:     if (abort)            state_next = IDLE;
                  else if (ctr == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= '0;
         sid       <= '0;
         ctr       <= '0;
         done      <= 1'b0;
         key_valid <= 1'b0;
         final_key <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (abort) begin
                  key_valid <= 1'b0;
               end else if (start) begin
                  k         <= seed_key;
                  sid       <= session_id;
                  ctr       <= '0;
                  key_valid <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  ctr       <= '0;
                  key_valid <= 1'b0;
               end else begin
                  k   <= k_round;
                  ctr <= ctr + 1'b1;
               end
            end
            DONE: begin
               ctr <= '0;
               if (abort) begin
                  key_valid <= 1'b0;
               end else begin
                  final_key <= k;
                  done      <= 1'b1;
                  key_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_final_key_generator.sv
// Directed bench for final_key_generator at ROUNDS = 1, 2 and 16.
module tb_final_key_generator;
   import evm_key_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:63] seed;
   logic [0:15] sid;

   logic        start_v [3];
   logic        abort_v [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic        kv_v    [3];
   logic [0:63] fk_v    [3];

   logic [0:63] kr_k;
   logic [0:15] kr_sid;
   logic [0:7]  kr_i;
   logic [0:63] kr_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   final_key_generator #(.ROUNDS(1), .ROT(13)) u_r1 (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
      .seed_key(seed), .session_id(sid), .busy(busy_v[0]), .done(done_v[0]),
      .key_valid(kv_v[0]), .final_key(fk_v[0]));

   final_key_generator #(.ROUNDS(2), .ROT(13)) u_r2 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
      .seed_key(seed), .session_id(sid), .busy(busy_v[1]), .done(done_v[1]),
      .key_valid(kv_v[1]), .final_key(fk_v[1]));

   final_key_generator #(.ROUNDS(16), .ROT(13)) u_r16 (
      .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
      .seed_key(seed), .session_id(sid), .busy(busy_v[2]), .done(done_v[2]),
      .key_valid(kv_v[2]), .final_key(fk_v[2]));

   key_round #(.ROT(13)) u_kr (.k(kr_k), .sid(kr_sid), .i(kr_i), .k_next(kr_out));

   typedef struct {
      int          sel;
      logic [63:0] seed;
      logic [15:0] sid;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [8];

   function automatic int rounds_of(input int sel);
      return (sel == 0) ? 1 : (sel == 1) ? 2 : 16;
   endfunction

   function automatic logic [63:0] ref_round(input logic [63:0] k, input logic [15:0] s,
                                             input logic [7:0] i);
      logic [127:0] d;
      logic [63:0]  r;
      d = {k, k};
      r = d[51 +: 64];
      return r ^ {3'b000, k[63:3]} ^ {s, s, s, s} ^ {56'h0, i};
   endfunction

   function automatic logic [63:0] model_key(input logic [63:0] s, input logic [15:0] id,
                                             input int r);
      logic [63:0] k;
      k = s;
      for (int i = 0; i < r; i++) k = ref_round(k, id, 8'(i));
      return k;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_one(input int sel, input logic [63:0] s, input logic [15:0] id,
                          output logic [63:0] key, output int cyc);
      @(negedge clk);
      seed = s;
      sid  = id;
      start_v[sel] = 1'b1;
      @(posedge clk);
      #1;
      start_v[sel] = 1'b0;
      seed = ~s;
      sid  = ~id;
      cyc  = 0;
      while (!done_v[sel] && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      key = fk_v[sel];
   endtask

   initial begin
      logic [63:0] key;
      logic [63:0] prev;
      int          cyc;
      int          ndone;
      int          tdone [$];

      rst = 1'b1;
      seed = '0;
      sid  = '0;
      kr_k = '0; kr_sid = '0; kr_i = '0;
      for (int j = 0; j < 3; j++) begin
         start_v[j] = 1'b0;
         abort_v[j] = 1'b0;
      end

      vecs[0] = '{0, 64'h0000_0000_0000_0001, 16'h0000, 64'h0000_0000_0000_2000};
      vecs[1] = '{0, 64'h0000_0000_0000_0000, 16'h0001, 64'h0001_0001_0001_0001};
      vecs[2] = '{0, 64'h8000_0000_0000_0000, 16'h0000, 64'h1000_0000_0000_1000};
      vecs[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 64'h1FFF_FFFF_FFFF_FFFF};
      vecs[4] = '{1, 64'h0000_0000_0000_0000, 16'h0000, 64'h0000_0000_0000_0001};
      vecs[5] = '{1, 64'h0000_0000_0000_0001, 16'h0000, 64'h0000_0000_0400_0401};
      vecs[6] = '{2, 64'h0123_4567_89AB_CDEF, 16'hBEEF,
                  model_key(64'h0123_4567_89AB_CDEF, 16'hBEEF, 16)};
      vecs[7] = '{2, 64'hDEAD_BEEF_0000_0001, 16'h1234,
                  model_key(64'hDEAD_BEEF_0000_0001, 16'h1234, 16)};

      #1;
      for (int j = 0; j < 3; j++) begin
         check($sformatf("reset busy[%0d]", j), 64'(busy_v[j]), 64'h0);
         check($sformatf("reset done[%0d]", j), 64'(done_v[j]), 64'h0);
         check($sformatf("reset key_valid[%0d]", j), 64'(kv_v[j]), 64'h0);
         check($sformatf("reset final_key[%0d]", j), fk_v[j], 64'h0);
      end
      #11 rst = 1'b0;

      kr_k = 64'h0123_4567_89AB_CDEF; kr_sid = 16'hA5C3; kr_i = 8'h07;
      #1 check("key_round a", kr_out, ref_round(64'h0123_4567_89AB_CDEF, 16'hA5C3, 8'h07));
      kr_k = 64'h8000_0000_0000_0001; kr_sid = 16'h0F0F; kr_i = 8'hFE;
      #1 check("key_round b", kr_out, ref_round(64'h8000_0000_0000_0001, 16'h0F0F, 8'hFE));

      for (int v = 0; v < 8; v++) begin
         run_one(vecs[v].sel, vecs[v].seed, vecs[v].sid, key, cyc);
         check($sformatf("vec%0d latency", v), 64'(cyc), 64'(rounds_of(vecs[v].sel) + 1));
         check($sformatf("vec%0d final_key", v), key, vecs[v].exp);
         check($sformatf("vec%0d key_valid", v), 64'(kv_v[vecs[v].sel]), 64'h1);
         check($sformatf("vec%0d busy", v), 64'(busy_v[vecs[v].sel]), 64'h0);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d done pulse width", v), 64'(done_v[vecs[v].sel]), 64'h0);
      end

      // Repeated start while RUN must not launch a second run.
      @(negedge clk);
      seed = '0; sid = '0;
      start_v[1] = 1'b1;
      ndone = 0;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk);
         #1;
         if (t == 2) start_v[1] = 1'b0;
         if (done_v[1]) ndone++;
      end
      check("busy restart done count", 64'(ndone), 64'd1);
      check("busy restart key", fk_v[1], 64'h1);

      // Abort five cycles into a ROUNDS=16 run.
      prev = fk_v[2];
      @(negedge clk);
      seed = 64'h5555_AAAA_5555_AAAA; sid = 16'h3C3C;
      start_v[2] = 1'b1;
      @(posedge clk);
      #1 start_v[2] = 1'b0;
      repeat (5) @(posedge clk);
      #1 abort_v[2] = 1'b1;
      @(posedge clk);
      #1 abort_v[2] = 1'b0;
      check("abort busy", 64'(busy_v[2]), 64'h0);
      check("abort key_valid", 64'(kv_v[2]), 64'h0);
      check("abort done", 64'(done_v[2]), 64'h0);
      check("abort final_key held", fk_v[2], prev);
      ndone = 0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #1;
         if (done_v[2]) ndone++;
      end
      check("abort no done", 64'(ndone), 64'd0);
      run_one(2, 64'h5555_AAAA_5555_AAAA, 16'h3C3C, key, cyc);
      check("post-abort latency", 64'(cyc), 64'd17);
      check("post-abort key", key, model_key(64'h5555_AAAA_5555_AAAA, 16'h3C3C, 16));

      // start together with abort: stays IDLE.
      @(negedge clk);
      start_v[2] = 1'b1; abort_v[2] = 1'b1;
      @(posedge clk);
      #1;
      start_v[2] = 1'b0; abort_v[2] = 1'b0;
      check("start+abort busy", 64'(busy_v[2]), 64'h0);
      check("start+abort key_valid", 64'(kv_v[2]), 64'h0);
      ndone = 0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #1;
         if (done_v[2]) ndone++;
      end
      check("start+abort no done", 64'(ndone), 64'd0);

      // Asynchronous reset between edges during RUN.
      @(negedge clk);
      start_v[2] = 1'b1;
      @(posedge clk);
      #1 start_v[2] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst busy", 64'(busy_v[2]), 64'h0);
      check("async rst done", 64'(done_v[2]), 64'h0);
      check("async rst key_valid", 64'(kv_v[2]), 64'h0);
      check("async rst final_key", fk_v[2], 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // start held for 40 cycles: back-to-back runs every ROUNDS+2 cycles.
      @(negedge clk);
      seed = 64'hCAFE_F00D_1234_5678; sid = 16'h9A9A;
      start_v[2] = 1'b1;
      for (int t = 0; t < 70; t++) begin
         @(posedge clk);
         #1;
         if (t == 39) start_v[2] = 1'b0;
         if (done_v[2]) begin
            tdone.push_back(t);
            check($sformatf("held start key @%0d", t), fk_v[2],
                  model_key(64'hCAFE_F00D_1234_5678, 16'h9A9A, 16));
         end
      end
      check("held start done count", 64'(tdone.size()), 64'd3);
      if (tdone.size() == 3) begin
         check("held start first done", 64'(tdone[0]), 64'd17);
         check("held start period 1", 64'(tdone[1] - tdone[0]), 64'd18);
         check("held start period 2", 64'(tdone[2] - tdone[1]), 64'd18);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/final_key_generator.md
Name: final_key_generator

Overview:
- Sequential key-schedule stage directly upstream of bit_level_mixing_encode; produces the 64-bit final_key that the encoder consumes alongside each 80-bit vote record.
- Expands a 64-bit seed key and a 16-bit session identifier over ROUNDS iterative rounds, one round per clock.
- Uses a start/busy/done handshake and holds the finished key stable, with key_valid, until the next start or abort.

Parameters:
- ROUNDS, 16, number of round iterations; legal range 1..255.
- ROT, 13, left-rotate amount per round; legal range 1..63.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- abort  input  1  synchronous cancel; wins over start.
- seed_key  input  [0:63]  initial key; bit 0 is the MSB.
- session_id  input  [0:15]  per-session diversifier; bit 0 is the MSB.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when final_key updates.
- key_valid  output  1  level; final_key holds a completed key.
- final_key  output  [0:63]  generated key, wired to bit_level_mixing_encode.final_key.

Behaviour:
- Reset is asynchronous, active-high, and is the only asynchronous path. On reset: state=IDLE; working key k=0; round counter ctr=0; busy=0; done=0; key_valid=0; final_key=0.
- Value convention: each vector is an unsigned integer with index 0 as the MSB. rotl and >> act on that integer.
- Round i (i = 0..ROUNDS-1):
  - k' = rotl(k, ROT) XOR (k >> 3) XOR {session_id, session_id, session_id, session_id} XOR zero_ext64(i).
  - i is the 8-bit counter value.
- IDLE state:
  - start=1 and abort=0: k<=seed_key; sid register<=session_id; ctr<=0; key_valid<=0; go to RUN.
  - abort=1: key_valid<=0; final_key unchanged.
- RUN state:
  - Each edge: k<=round(k, ctr); ctr<=ctr+1.
  - When ctr==ROUNDS-1, go to DONE on that edge.
  - start is ignored.
- DONE state:
  - final_key<=k; done<=1 for exactly one cycle; key_valid<=1; go to IDLE.
- Latency: start sampled at edge E. Rounds occur at edges E+1..E+ROUNDS. done and key_valid go high after edge E+ROUNDS+1. Total: ROUNDS+1 cycles.
- Session id: taken from the register latched at start. Changes on session_id or seed_key while busy have no effect.
- abort in RUN or DONE: next edge goes to IDLE, with busy=0, done=0, key_valid=0, ctr=0. final_key keeps its last completed value, but key_valid=0 marks it stale.
- start and abort in the same cycle: abort wins; no run begins.
- start held high: re-accepted on the first IDLE cycle after done, so back-to-back runs have a period of ROUNDS+2 cycles.
- Counter: 8 bits, never wraps because ROUNDS≤255.
- No combinational path from inputs to outputs.

Decomposition:
- Package evm_key_pkg:
  - KEY_W=64, SID_W=16, CTR_W=8.
  - State enum IDLE/RUN/DONE, 2-bit encoding.
  - Default ROUNDS/ROT constants.
- Sub-module key_round: purely combinational round function. Inputs k, sid, i; parameter ROT; output k'.
  - Instantiated once in final_key_generator.
  - Reused by the bench's reference model.

Test Plan:
- ROUNDS=1, ROT=13, seed=64'h0000_0000_0000_0001, sid=0, start pulse → done after 2 cycles; final_key=64'h0000_0000_0000_2000; key_valid=1.
- ROUNDS=1, seed=0, sid=16'h0001 → final_key=64'h0001_0001_0001_0001.
- ROUNDS=2, seed=0, sid=0 → done at cycle 3, final_key=64'h0000_0000_0000_0001; a second start pulse while busy is ignored (exactly one done).
- ROUNDS=16, abort at 5 cycles after start → busy=0, key_valid=0, no done pulse; final_key retains its previous value. A fresh start then completes in 17 cycles and matches the key_round model.
- Assert rst mid-RUN (async, between edges) → all outputs 0 immediately. start with abort=1 in the same cycle → stays IDLE.
- start held high for 40 cycles, ROUNDS=16 → done pulses every 18 cycles. Each final_key matches the model, and data_out of a downstream bit_level_mixing_encode matches 80'h78556327897855632789 encoded under that key.
